// File: rtl/apb_mem_slave_if.sv
// APB3 bus bundle between the interconnect (master side) and the memory
// bridge (slave side). Clock and reset stay outside as plain ports.
interface apb_mem_slave_if #(
  parameter int APB_AW = 32,
  parameter int PDW    = 32
);
  logic [APB_AW-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [PDW-1:0]    pwdata;
  logic [PDW-1:0]    prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB3 slave front-end for a small scratch memory. Each APB access becomes a
// single ce/rden/wren request; the bridge waits for the memory's one-cycle
// ready pulse and returns data and status. Accesses outside the address
// window and requests the memory never answers complete with pslverr.
module apb_mem_slave #(
  parameter int                APB_AW    = 32,
  parameter int                PDW       = 32,
  parameter int                MEM_AW    = 8,
  parameter int                DW        = 8,
  parameter logic [APB_AW-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  apb_mem_slave_if.slave       apb,
  output logic                 mem_ce,
  output logic                 mem_rden,
  output logic                 mem_wren,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 mem_ready
);

  // Wide enough to hold TIMEOUT-1 without wrapping.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            in_window;
  logic            unused_pwdata;

  // Only the low DW bits of pwdata reach the memory; the rest is ignored.
  assign unused_pwdata = ^apb.pwdata;

  // The window is the aligned 2**MEM_AW block starting at BASE_ADDR.
  assign in_window = (apb.paddr[APB_AW-1:MEM_AW] == BASE_ADDR[APB_AW-1:MEM_AW]);

  // Bridge FSM: every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      apb.prdata  <= '0;
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      mem_ce      <= 1'b0;
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          apb.pready  <= 1'b0;
          apb.pslverr <= 1'b0;
          mem_ce      <= 1'b0;
          mem_rden    <= 1'b0;
          mem_wren    <= 1'b0;
          if (apb.psel && apb.penable) begin
            if (in_window) begin
              mem_addr   <= apb.paddr[MEM_AW-1:0];
              mem_wdata  <= apb.pwdata[DW-1:0];
              mem_ce     <= 1'b1;
              mem_rden   <= !apb.pwrite;
              mem_wren   <= apb.pwrite;
              count      <= '0;
              apb.prdata <= '0;
              state      <= REQ;
            end else begin
              apb.pready  <= 1'b1;
              apb.pslverr <= 1'b1;
              apb.prdata  <= '0;
              state       <= RESP;
            end
          end
        end

        REQ: begin
          count <= count + 1'b1;
          // A ready on the timeout edge still counts as a good completion.
          if (mem_ready) begin
            if (!mem_wren) begin
              apb.prdata <= PDW'(mem_rdata);
            end
            apb.pready  <= 1'b1;
            apb.pslverr <= 1'b0;
            mem_ce      <= 1'b0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
            state       <= RESP;
          end else if (count == CW'(TIMEOUT - 1)) begin
            apb.pready  <= 1'b1;
            apb.pslverr <= 1'b1;
            apb.prdata  <= '0;
            mem_ce      <= 1'b0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
            state       <= RESP;
          end else if (!apb.psel) begin
            // Master walked away mid-transfer: drop the request silently.
            mem_ce   <= 1'b0;
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            state    <= IDLE;
          end
        end

        RESP: begin
          // The master samples pready on this edge; penable is still high,
          // so this cycle must not be taken as a new access.
          apb.pready  <= 1'b0;
          apb.pslverr <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: a behavioural 256x8 memory with a
// one-cycle ready pulse, an APB master task, and a scoreboard whose monitor
// checks every pready response against expectations queued at issue time.
module tb_apb_mem_slave;

  localparam int          APB_AW  = 32;
  localparam int          PDW     = 32;
  localparam int          MEM_AW  = 8;
  localparam int          DW      = 8;
  localparam logic [31:0] BASE    = 32'h0;
  localparam int          TIMEOUT = 15;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mem_ce;
  logic             mem_rden;
  logic             mem_wren;
  logic [7:0]       mem_addr;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata = 8'h00;
  logic             mem_ready = 1'b0;
  logic             mem_ready_en = 1'b1;

  logic [7:0]       mem_array [256];
  logic [7:0]       ref_mem [256];
  exp_t             exp_q [$];

  int               tests = 0;
  int               failures = 0;
  int               ce_cycles = 0;
  int               req_count = 0;
  int               exp_req = 0;
  logic             ce_prev = 1'b0;
  logic [7:0]       cur_addr = 8'h00;
  logic             cur_write = 1'b0;
  logic [7:0]       cur_wdata = 8'h00;

  apb_mem_slave_if #(.APB_AW(APB_AW), .PDW(PDW)) bus ();

  apb_mem_slave #(
    .APB_AW   (APB_AW),
    .PDW      (PDW),
    .MEM_AW   (MEM_AW),
    .DW       (DW),
    .BASE_ADDR(BASE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .apb      (bus),
    .mem_ce   (mem_ce),
    .mem_rden (mem_rden),
    .mem_wren (mem_wren),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Behavioural memory: executes whenever ce is sampled, ready is a single pulse.
  always @(posedge clk) begin
    if (mem_ready_en && mem_ce) begin
      if (mem_wren) mem_array[mem_addr] <= mem_wdata;
      mem_rdata <= mem_array[mem_addr];
    end
    mem_ready <= mem_ready_en && mem_ce && !mem_ready;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: checks the memory request contents and pops one expectation per pready.
  always @(negedge clk) begin
    if (!rst_n) begin
      ce_prev = 1'b0;
    end else begin
      if (mem_ce) begin
        ce_cycles++;
        checkOutput("mem_wren", {31'b0, mem_wren}, {31'b0, cur_write});
        checkOutput("mem_rden", {31'b0, mem_rden}, {31'b0, !cur_write});
        checkOutput("mem_addr", {24'b0, mem_addr}, {24'b0, cur_addr});
        if (cur_write) checkOutput("mem_wdata", {24'b0, mem_wdata}, {24'b0, cur_wdata});
      end
      if (mem_ce && !ce_prev) req_count++;
      ce_prev = mem_ce;
      if (bus.pready) begin
        if (exp_q.size() == 0) begin
          tests++;
          failures++;
          $display("[TB] FAIL spurious_pready: got pready=1, expected no response at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("prdata", bus.prdata, e.data);
          checkOutput("pslverr", {31'b0, bus.pslverr}, {31'b0, e.err});
        end
      end
    end
  end

  // One complete APB transfer; caller is positioned just after a rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic write,
                               input logic [31:0] wdata);
    exp_t e;
    int   exp_lat;
    int   exp_ce;
    int   ce_start;
    int   cycles;
    logic done;
    logic in_win;
    in_win = ((addr >> MEM_AW) == (BASE >> MEM_AW));
    e.data = 32'h0;
    if (!in_win) begin
      e.err = 1'b1; exp_lat = 1; exp_ce = 0;
    end else if (!mem_ready_en) begin
      e.err = 1'b1; exp_lat = TIMEOUT + 1; exp_ce = TIMEOUT; exp_req++;
    end else if (write) begin
      ref_mem[addr % 256] = wdata[7:0];
      e.err = 1'b0; exp_lat = 3; exp_ce = 2; exp_req++;
    end else begin
      e.data = {24'b0, ref_mem[addr % 256]};
      e.err = 1'b0; exp_lat = 3; exp_ce = 2; exp_req++;
    end
    cur_addr  = addr[7:0];
    cur_write = write;
    cur_wdata = wdata[7:0];
    exp_q.push_back(e);
    bus.paddr   = addr;
    bus.pwrite  = write;
    bus.pwdata  = wdata;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    ce_start = ce_cycles;
    cycles = 0;
    done = 1'b0;
    while (!done && cycles < 40) begin
      @(posedge clk);
      cycles++;
      #1;
      if (bus.pready) done = 1'b1;
    end
    if (!done) begin
      tests++;
      failures++;
      $display("[TB] FAIL pready_wait: got no pready in 40 cycles, expected one after %0d", exp_lat);
    end else begin
      checkOutput("latency", cycles, exp_lat);
    end
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    checkOutput("mem_ce_cycles", ce_cycles - ce_start, exp_ce);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_array[i] = 8'(i);
      ref_mem[i]   = 8'(i);
    end
    bus.paddr = '0; bus.psel = 1'b0; bus.penable = 1'b0;
    bus.pwrite = 1'b0; bus.pwdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pready", {31'b0, bus.pready}, 32'h0);
    checkOutput("rst_pslverr", {31'b0, bus.pslverr}, 32'h0);
    checkOutput("rst_prdata", bus.prdata, 32'h0);
    checkOutput("rst_mem_ce", {31'b0, mem_ce}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic read, write then read back, out-of-window access
    applyStimulus(32'h05, 1'b0, 32'h0);
    applyStimulus(32'h10, 1'b1, 32'h123456A5);
    applyStimulus(32'h10, 1'b0, 32'h0);
    applyStimulus(32'h100, 1'b0, 32'h0);

    // Memory never answers: timeout, then recovery
    mem_ready_en = 1'b0;
    applyStimulus(32'h20, 1'b0, 32'h0);
    mem_ready_en = 1'b1;
    applyStimulus(32'h21, 1'b0, 32'h0);

    // Asynchronous reset while a request is pending
    mem_ready_en = 1'b0;
    cur_addr = 8'h30; cur_write = 1'b0;
    exp_req++;
    bus.paddr = 32'h30; bus.pwrite = 1'b0; bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0;
    #1;
    checkOutput("arst_mem_ce", {31'b0, mem_ce}, 32'h0);
    checkOutput("arst_mem_rden", {31'b0, mem_rden}, 32'h0);
    checkOutput("arst_mem_addr", {24'b0, mem_addr}, 32'h0);
    checkOutput("arst_pready", {31'b0, bus.pready}, 32'h0);
    checkOutput("arst_prdata", bus.prdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready_en = 1'b1;
    applyStimulus(32'h07, 1'b0, 32'h0);

    // Back-to-back writes then reads
    for (int i = 0; i < 16; i++)
      applyStimulus(32'(i), 1'b1, {$urandom_range(0, 255), 8'(8'hF0 + i)} & 32'h0000FFFF);
    for (int i = 0; i < 16; i++)
      applyStimulus(32'(i), 1'b0, 32'h0);

    // Randomised mix, including out-of-window addresses
    for (int i = 0; i < 40; i++)
      applyStimulus(32'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), $urandom);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("mem_requests", req_count, exp_req);
    checkOutput("queue_empty", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
